// File: rtl/font_dma_pkg.sv
// Shared types and default geometry for the font ROM DMA scheduler.
package font_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int unsigned DFLT_FONT_GLYPHS = 64;
    localparam int unsigned DFLT_FONT_HEIGHT = 8;
    localparam int unsigned GLYPH_W          = $clog2(DFLT_FONT_GLYPHS);
    localparam int unsigned LINE_W           = $clog2(DFLT_FONT_HEIGHT);
    localparam int unsigned ADDR_W           = GLYPH_W + LINE_W;

    // Index width for an N-entry select; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/font_dma_sched_prio.sv
// LSB-first priority encoder: lowest set bit of the mask as index and one-hot.
module prio_enc_lsb
    import font_dma_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          valid,
    output logic [N-1:0]  onehot
);

    // Scan downward so the lowest set bit is the last one to win.
    always_comb begin
        idx    = '0;
        valid  = |mask;
        onehot = mask & (~mask + N'(1));
        for (int i = N - 1; i >= 0; i--) begin
            idx = mask[i] ? IW'(i) : idx;
        end
    end

endmodule

// File: rtl/font_dma_sched.sv
// Time-shares one synchronous font ROM between NSPR text sprites, fetching
// one glyph line per requesting sprite at the start of every h-blank.
module font_dma_sched
    import font_dma_pkg::*;
#(
    parameter int unsigned NSPR        = 4,
    parameter int unsigned FONT_WIDTH  = 8,
    parameter int unsigned FONT_HEIGHT = DFLT_FONT_HEIGHT,
    parameter int unsigned FONT_GLYPHS = DFLT_FONT_GLYPHS,
    parameter int unsigned ROM_LAT     = 1
) (
    input  logic                                          clk_pix,
    input  logic                                          rst_pix,
    input  logic                                          line,
    input  logic [NSPR-1:0]                               req,
    input  logic [NSPR*$clog2(FONT_GLYPHS)-1:0]           glyph_code,
    input  logic [NSPR*$clog2(FONT_HEIGHT)-1:0]           glyph_line,
    output logic [$clog2(FONT_GLYPHS*FONT_HEIGHT)-1:0]    rom_addr,
    input  logic [FONT_WIDTH-1:0]                         rom_data,
    output logic [NSPR-1:0]                               grant,
    output logic [NSPR-1:0]                               ld,
    output logic [FONT_WIDTH-1:0]                         ld_data,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          overrun
);

    localparam int unsigned CW = $clog2(FONT_GLYPHS);
    localparam int unsigned RW = $clog2(FONT_HEIGHT);
    localparam int unsigned AW = CW + RW;
    localparam int unsigned IW = idx_width(NSPR);
    localparam int unsigned DW = (ROM_LAT > 32'd1) ? $clog2(ROM_LAT) : 32'd1;

    state_t            state_r, state_s;
    logic [NSPR-1:0]   pending_r, pending_s;
    logic [NSPR-1:0]   grant_r, grant_s;
    logic [AW-1:0]     addr_r, addr_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              overrun_r, overrun_s;
    logic [DW-1:0]     drain_r, drain_s;
    logic [NSPR*CW-1:0] code_r, code_src_s;
    logic [NSPR*RW-1:0] row_r, row_src_s;
    logic [NSPR-1:0]   ld_pipe_r [ROM_LAT];
    logic [NSPR-1:0]   mask_s, onehot_s;
    logic [IW-1:0]     idx_s;
    logic              valid_s;
    logic              accept_s;
    logic              issue_s;

    // A new round is accepted only from IDLE; the first grant comes from the live inputs.
    always_comb begin
        accept_s   = line && (state_r == IDLE);
        mask_s     = (state_r == IDLE) ? req        : pending_r;
        code_src_s = (state_r == IDLE) ? glyph_code : code_r;
        row_src_s  = (state_r == IDLE) ? glyph_line : row_r;
        issue_s    = valid_s && (accept_s || (state_r == ISSUE));
    end

    prio_enc_lsb #(.N(NSPR)) u_prio (
        .mask   (mask_s),
        .idx    (idx_s),
        .valid  (valid_s),
        .onehot (onehot_s)
    );

    // Next-state and registered-output logic of the fetch FSM.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        grant_s   = '0;
        addr_s    = '0;
        drain_s   = drain_r;
        done_s    = 1'b0;
        if (line && busy_r) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end
        if (issue_s) begin
            grant_s   = onehot_s;
            addr_s    = {code_src_s[idx_s*CW +: CW], row_src_s[idx_s*RW +: RW]};
            pending_s = mask_s & ~onehot_s;
        end else begin
            pending_s = pending_r;
        end
        case (state_r)
            IDLE: begin
                if (!line) begin
                    state_s = IDLE;
                end else if (!valid_s) begin
                    state_s = FIN;
                    done_s  = 1'b1;
                end else if (pending_s == '0) begin
                    state_s = DRAIN;
                    drain_s = DW'(ROM_LAT - 32'd1);
                end else begin
                    state_s = ISSUE;
                end
            end
            ISSUE: begin
                if (pending_s == '0) begin
                    state_s = DRAIN;
                    drain_s = DW'(ROM_LAT - 32'd1);
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (drain_r == '0) begin
                    state_s = FIN;
                    done_s  = 1'b1;
                end else begin
                    drain_s = drain_r - DW'(1);
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_r   <= IDLE;
            pending_r <= '0;
            grant_r   <= '0;
            addr_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            drain_r   <= '0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            grant_r   <= grant_s;
            addr_r    <= addr_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            overrun_r <= overrun_s;
            drain_r   <= drain_s;
        end
    end

    // Snapshot glyph codes and rows at acceptance so callers may change them mid-round.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            code_r <= '0;
            row_r  <= '0;
        end else if (accept_s) begin
            code_r <= glyph_code;
            row_r  <= glyph_line;
        end
    end

    // Delay each grant by the ROM latency to mark when its data is on rom_data.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            for (int i = 0; i < int'(ROM_LAT); i++) begin
                ld_pipe_r[i] <= '0;
            end
        end else begin
            ld_pipe_r[0] <= grant_r;
            for (int i = 1; i < int'(ROM_LAT); i++) begin
                ld_pipe_r[i] <= ld_pipe_r[i-1];
            end
        end
    end

    assign rom_addr = addr_r;
    assign grant    = grant_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overrun  = overrun_r;
    assign ld       = ld_pipe_r[ROM_LAT-1];
    assign ld_data  = rom_data;

endmodule

// File: tb/tb_font_dma_sched.sv
// Self-checking bench for font_dma_sched: per-cycle vector tables plus a
// scoreboard of expected glyph loads fed by a model synchronous ROM.
module tb_font_dma_sched;
    import font_dma_pkg::*;

    logic                clk_pix = 1'b0;
    logic                rst_pix;
    logic                line;
    logic [3:0]          req;
    logic [4*GLYPH_W-1:0] glyph_code;
    logic [4*LINE_W-1:0]  glyph_line;
    logic [ADDR_W-1:0]   rom_addr;
    logic [7:0]          rom_data = 8'h00;
    logic [3:0]          grant;
    logic [3:0]          ld;
    logic [7:0]          ld_data;
    logic                busy;
    logic                done;
    logic                overrun;

    font_dma_sched #(
        .NSPR(4), .FONT_WIDTH(8), .FONT_HEIGHT(8), .FONT_GLYPHS(64), .ROM_LAT(1)
    ) dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .line       (line),
        .req        (req),
        .glyph_code (glyph_code),
        .glyph_line (glyph_line),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .grant      (grant),
        .ld         (ld),
        .ld_data    (ld_data),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk_pix = ~clk_pix;

    function automatic logic [7:0] rom_fn(input logic [ADDR_W-1:0] a);
        logic [15:0] t;
        t = {7'd0, a} * 16'd37 + 16'd11;
        return t[7:0] ^ t[15:8];
    endfunction

    // Model font ROM with one cycle of read latency.
    always @(posedge clk_pix) rom_data <= rom_fn(rom_addr);

    typedef struct {
        logic       line;
        logic [3:0] req;
        logic [3:0] grant;
        logic [8:0] addr;
        logic       busy;
        logic       done;
        logic [3:0] ld;
    } vec_t;

    typedef struct {
        logic [3:0] ld;
        logic [7:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    vec_t idle_v;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic ov_model = 1'b0;
    logic [4*GLYPH_W-1:0] base_code;
    logic [4*LINE_W-1:0]  base_row;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic add(input logic ln, input logic [3:0] rq, input logic [3:0] g,
                       input logic [8:0] a, input logic b, input logic d, input logic [3:0] l);
        vec_t v;
        v.line = ln; v.req = rq; v.grant = g; v.addr = a; v.busy = b; v.done = d; v.ld = l;
        vecs.push_back(v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, ".grant"},    32'(grant),    32'd0);
        chk({tag, ".ld"},       32'(ld),       32'd0);
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
        chk({tag, ".overrun"},  32'(overrun),  32'd0);
    endtask

    // Check this cycle's outputs, then drive the inputs sampled at the next edge.
    task automatic apply_row(input vec_t v);
        @(negedge clk_pix);
        chk("grant",    32'(grant),    32'(v.grant));
        chk("rom_addr", 32'(rom_addr), 32'(v.addr));
        chk("busy",     32'(busy),     32'(v.busy));
        chk("done",     32'(done),     32'(v.done));
        chk("ld",       32'(ld),       32'(v.ld));
        chk("overrun",  32'(overrun),  32'(ov_model));
        if (v.line && v.busy) ov_model = 1'b1;
        if (v.line && !v.busy) begin
            for (int i = 0; i < 4; i++) begin
                if (v.req[i]) begin
                    sb_t e;
                    e.ld   = 4'(1 << i);
                    e.data = rom_fn({base_code[i*GLYPH_W +: GLYPH_W], base_row[i*LINE_W +: LINE_W]});
                    sb.push_back(e);
                end
            end
        end
        if (v.line) begin
            line = 1'b1; req = v.req; glyph_code = base_code; glyph_line = base_row;
        end else begin
            line = 1'b0; req = ~v.req; glyph_code = ~base_code; glyph_line = ~base_row;
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply_row(vecs[i]);
    endtask

    // Scoreboard: every load must match the next expected sprite and glyph data.
    always @(negedge clk_pix) begin
        if (!rst_pix && ld != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("ld_unexpected", 32'(ld), 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_ld",      32'(ld),      32'(e.ld));
                chk("sb_ld_data", 32'(ld_data), 32'(e.data));
            end
        end
    end

    initial begin
        rst_pix = 1'b1; line = 1'b0; req = 4'b0000;
        glyph_code = '0; glyph_line = '0;
        base_code = {6'h33, 6'h2C, 6'h21, 6'h26};
        base_row  = {4{3'd3}};
        idle_v = '{line: 1'b0, req: 4'h0, grant: 4'h0, addr: 9'h000, busy: 1'b0, done: 1'b0, ld: 4'h0};

        // full round, rows 0..6
        add(1'b1, 4'b1111, 4'b0000, 9'h000, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 4'b1111, 4'b0001, 9'h133, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 4'b1111, 4'b0010, 9'h10B, 1'b1, 1'b0, 4'b0001);
        add(1'b0, 4'b1111, 4'b0100, 9'h163, 1'b1, 1'b0, 4'b0010);
        add(1'b0, 4'b1111, 4'b1000, 9'h19B, 1'b1, 1'b0, 4'b0100);
        add(1'b0, 4'b1111, 4'b0000, 9'h000, 1'b1, 1'b1, 4'b1000);
        add(1'b0, 4'b1111, 4'b0000, 9'h000, 1'b0, 1'b0, 4'b0000);
        // sparse request, rows 7..11
        add(1'b1, 4'b1010, 4'b0000, 9'h000, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 4'b1010, 4'b0010, 9'h10B, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 4'b1010, 4'b1000, 9'h19B, 1'b1, 1'b0, 4'b0010);
        add(1'b0, 4'b1010, 4'b0000, 9'h000, 1'b1, 1'b1, 4'b1000);
        add(1'b0, 4'b1010, 4'b0000, 9'h000, 1'b0, 1'b0, 4'b0000);
        // empty round, rows 12..14
        add(1'b1, 4'b0000, 4'b0000, 9'h000, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 4'b0000, 4'b0000, 9'h000, 1'b1, 1'b1, 4'b0000);
        add(1'b0, 4'b0000, 4'b0000, 9'h000, 1'b0, 1'b0, 4'b0000);
        // full round with a dropped line at T+2, rows 15..21
        add(1'b1, 4'b1111, 4'b0000, 9'h000, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 4'b1111, 4'b0001, 9'h133, 1'b1, 1'b0, 4'b0000);
        add(1'b1, 4'b1111, 4'b0010, 9'h10B, 1'b1, 1'b0, 4'b0001);
        add(1'b0, 4'b1111, 4'b0100, 9'h163, 1'b1, 1'b0, 4'b0010);
        add(1'b0, 4'b1111, 4'b1000, 9'h19B, 1'b1, 1'b0, 4'b0100);
        add(1'b0, 4'b1111, 4'b0000, 9'h000, 1'b1, 1'b1, 4'b1000);
        add(1'b0, 4'b1111, 4'b0000, 9'h000, 1'b0, 1'b0, 4'b0000);

        repeat (2) @(negedge clk_pix);
        chk_all_zero("rst_hold");
        rst_pix = 1'b0;
        repeat (3) apply_row(idle_v);

        run(0, 7);
        run(7, 12);
        run(12, 15);
        run(15, 22);

        // reset pulsed in T+2 of a full round
        run(0, 3);
        #1 rst_pix = 1'b1;
        #1 chk_all_zero("rst_async");
        sb.delete();
        ov_model = 1'b0;
        #1 rst_pix = 1'b0;
        repeat (3) apply_row(idle_v);
        run(0, 7);
        repeat (2) apply_row(idle_v);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
